// File: rtl/mem_reverse_engine.sv
// In-place reversal of a word region in data memory, one access per cycle.
// Define BYTE_REVERSE_EN to also byte-reverse every written word and swap the odd middle word.
module mem_reverse_engine #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_WR_LO,
        S_WR_HI,
        S_DONE
`ifdef BYTE_REVERSE_EN
        ,
        S_MID_RD,
        S_MID_WR
`endif
    } state_e;

    localparam logic [ADDR_W:0]   ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W+1:0] LIMIT = {2'b01, {ADDR_W{1'b0}}};

    state_e             state_q, state_d;
    logic [ADDR_W:0]    lo_q, lo_d;
    logic [ADDR_W:0]    hi_q, hi_d;
    logic [WIDTH-1:0]   tmp_q, tmp_d;
    logic               err_q, err_d;

    logic [ADDR_W+1:0]  end_w;
    logic               range_bad;
    logic [ADDR_W:0]    hi_start;
    logic [ADDR_W:0]    lo_nx;
    logic [ADDR_W:0]    hi_nx;

    // One past the last word, kept a bit wider so base+len cannot wrap.
    assign end_w     = {1'b0, 1'b0, base_i} + {1'b0, len_i};
    assign range_bad = end_w > LIMIT;
    assign hi_start  = {1'b0, base_i} + len_i - ONE;
    assign lo_nx     = lo_q + ONE;
    assign hi_nx     = hi_q - ONE;

    function automatic logic [WIDTH-1:0] wfmt(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
`ifdef BYTE_REVERSE_EN
        for (int b = 0; b < WIDTH/8; b++) begin
            r[8*b +: 8] = w[WIDTH-8-8*b +: 8];
        end
`else
        r = w;
`endif
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            lo_q    <= '0;
            hi_q    <= '0;
            tmp_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            tmp_q   <= tmp_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        tmp_d       = tmp_q;
        err_d       = err_q;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lo_d  = {1'b0, base_i};
                    hi_d  = hi_start;
                    err_d = range_bad;
                    if (range_bad || len_i == '0) begin
                        state_d = S_DONE;
                    end else if (len_i == ONE) begin
`ifdef BYTE_REVERSE_EN
                        state_d = S_MID_RD;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_RD_LO;
                    end
                end
            end
            S_RD_LO: begin
                busy_o     = 1'b1;
                mem_addr_o = lo_q[ADDR_W-1:0];
                state_d    = S_RD_HI;
            end
            S_RD_HI: begin
                // Read data here is the lo word requested last cycle.
                busy_o     = 1'b1;
                mem_addr_o = hi_q[ADDR_W-1:0];
                tmp_d      = mem_rdata_i;
                state_d    = S_WR_LO;
            end
            S_WR_LO: begin
                busy_o      = 1'b1;
                mem_addr_o  = lo_q[ADDR_W-1:0];
                mem_we_o    = 1'b1;
                mem_wdata_o = wfmt(mem_rdata_i);
                state_d     = S_WR_HI;
            end
            S_WR_HI: begin
                busy_o      = 1'b1;
                mem_addr_o  = hi_q[ADDR_W-1:0];
                mem_we_o    = 1'b1;
                mem_wdata_o = wfmt(tmp_q);
                lo_d        = lo_nx;
                hi_d        = hi_nx;
                if (lo_nx < hi_nx) begin
                    state_d = S_RD_LO;
`ifdef BYTE_REVERSE_EN
                end else if (lo_nx == hi_nx) begin
                    state_d = S_MID_RD;
`endif
                end else begin
                    state_d = S_DONE;
                end
            end
`ifdef BYTE_REVERSE_EN
            S_MID_RD: begin
                busy_o     = 1'b1;
                mem_addr_o = lo_q[ADDR_W-1:0];
                state_d    = S_MID_WR;
            end
            S_MID_WR: begin
                busy_o      = 1'b1;
                mem_addr_o  = lo_q[ADDR_W-1:0];
                mem_we_o    = 1'b1;
                mem_wdata_o = wfmt(mem_rdata_i);
                state_d     = S_DONE;
            end
`endif
            S_DONE: begin
                done_o  = 1'b1;
                err_o   = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
